// File: rtl/gray_hist_pkg.sv
// gray_hist_pkg: shared state encoding, bin count and counter saturation helper
// for the gray histogram block.
package gray_hist_pkg;

    localparam int NUM_BINS = 256;

    typedef enum logic [1:0] {
        CLRMEM  = 2'd0,
        ACCUM   = 2'd1,
        DRAIN   = 2'd2,
        READOUT = 2'd3
    } state_t;

    // All-ones value of a w-bit counter, clamped to 32 bits.
    function automatic logic [31:0] sat_max(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/gray_hist_ram.sv
// gray_hist_ram: bin counter storage, one write port and one synchronous read
// port (read-old-data on same-address collision), contents not reset.
module gray_hist_ram #(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/gray_histogram.sv
// gray_histogram: per-frame 256-bin histogram of gray samples, streamed out over
// valid/ready and then self-cleared. Define GRAY_HISTOGRAM_MAXBIN_EN for max_bin/max_count.
module gray_histogram
    import gray_hist_pkg::*;
#(
    parameter int CNT_W = 20,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [PIX_W-1:0] gray_in,
    input  logic             gray_valid,
    input  logic             frame_end,
    output logic [PIX_W-1:0] bin_idx,
    output logic [CNT_W-1:0] bin_count,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             bin_last,
    output logic             busy,
    output logic             drop
`ifdef GRAY_HISTOGRAM_MAXBIN_EN
    ,
    output logic [PIX_W-1:0] max_bin,
    output logic [CNT_W-1:0] max_count
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
    localparam logic [PIX_W-1:0] LAST_IDX = '1;

    state_t           state, nxt;
    logic [PIX_W-1:0] addr;
    logic [1:0]       vld_pipe;     // [0]: read in flight, [1]: write-back pending
    logic [PIX_W-1:0] s1_bin, s2_bin, waddr, raddr;
    logic [CNT_W-1:0] s2_data, fwd_data, s1_cur, s1_inc, rdata, wdata;
    logic             fwd_hit, out_vld, primed, accept, we;

    gray_hist_ram #(.AW(PIX_W), .DEPTH(NUM_BINS), .DW(CNT_W)) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign accept = out_vld && bin_ready;

    // Newest value wins: the write happening now, else the write that landed as the read was taken.
    assign s1_cur = (vld_pipe[1] && s2_bin == s1_bin) ? s2_data : (fwd_hit ? fwd_data : rdata);
    assign s1_inc = (s1_cur == CNT_MAX) ? s1_cur : s1_cur + 1'b1;

    always_ff @(posedge clk) begin
        if (clear) state <= CLRMEM;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            CLRMEM:  if (addr == LAST_IDX) nxt = ACCUM;
            ACCUM:   if (frame_end) nxt = DRAIN;
            // Stage 2 retires on this edge, so the first readout read sees it.
            DRAIN:   if (!vld_pipe[0]) nxt = READOUT;
            READOUT: if (accept && addr == LAST_IDX) nxt = CLRMEM;
            default: nxt = CLRMEM;
        endcase
    end

    always_comb begin
        we    = vld_pipe[1];
        waddr = s2_bin;
        wdata = s2_data;
        raddr = gray_in;
        busy  = 1'b1;
        case (state)
            CLRMEM: begin
                we    = 1'b1;
                waddr = addr;
                wdata = '0;
            end
            ACCUM:   busy = 1'b0;
            // Counts are static here, so re-reading the presented bin holds it stable.
            READOUT: raddr = accept ? addr + 1'b1 : addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            addr     <= '0;
            vld_pipe <= '0;
            fwd_hit  <= 1'b0;
            out_vld  <= 1'b0;
            primed   <= 1'b0;
            drop     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], gray_valid && state == ACCUM};
            fwd_hit  <= vld_pipe[1] && s2_bin == raddr;
            if (gray_valid && state != ACCUM) drop <= 1'b1;
            case (state)
                CLRMEM: addr <= addr + 1'b1;
                DRAIN: begin
                    addr   <= '0;
                    primed <= 1'b0;
                end
                READOUT: begin
                    primed <= 1'b1;
                    if (primed && !out_vld) out_vld <= 1'b1;
                    if (accept) begin
                        addr <= addr + 1'b1;
                        if (addr == LAST_IDX) out_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        s1_bin   <= gray_in;
        s2_bin   <= s1_bin;
        s2_data  <= s1_inc;
        fwd_data <= s2_data;
    end

    assign bin_valid = out_vld;
    assign bin_idx   = out_vld ? addr : '0;
    assign bin_count = out_vld ? rdata : '0;
    assign bin_last  = out_vld && addr == LAST_IDX;

`ifdef GRAY_HISTOGRAM_MAXBIN_EN
    always_ff @(posedge clk) begin
        if (clear || (state == DRAIN && nxt == READOUT)) begin
            max_bin   <= '0;
            max_count <= '0;
        end else if (accept && bin_count > max_count) begin
            max_bin   <= addr;
            max_count <= bin_count;
        end
    end
`endif

endmodule
